// File: rtl/calc1_pkg.sv
// Shared command/response encodings and FSM state type for the calc1 port responder.
package calc1_pkg;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        OPND2,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 datapath: add/sub/shift with all error rules.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [0:3]    cmd,
    input  logic [0:DW-1] op1,
    input  logic [0:DW-1] op2,
    output logic [0:1]    resp,
    output logic [0:DW-1] data
);

    logic [0:DW] sum;
    logic [0:4]  amt;

    assign sum = {1'b0, op1} + {1'b0, op2};
    assign amt = op2[DW-5:DW-1];

    always_comb begin
        resp = RESP_ERR;
        data = '0;
        unique case (cmd)
            CMD_ADD: begin
                // carry out of the MSB is an overflow
                if (!sum[0]) begin
                    resp = RESP_OK;
                    data = sum[1:DW];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << amt;
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> amt;
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// One calc1 request port: two-beat request capture, fixed latency, one response beat.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LATENCY = 3
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [0:3]    req_cmd_in,
    input  logic [0:DW-1] req_data_in,
    output logic [0:1]    out_resp,
    output logic [0:DW-1] out_data,
    output logic          busy
);

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [0:3]    cmd_q, cmd_n;
    logic [0:DW-1] op1, op1_n;
    logic [0:DW-1] op2, op2_n;
    logic [0:1]    resp_n;
    logic [0:DW-1] data_n;
    logic          busy_n;
    logic [0:1]    alu_resp;
    logic [0:DW-1] alu_data;

    calc1_alu #(.DW(DW)) u_alu (
        .cmd  (cmd_q),
        .op1  (op1),
        .op2  (op2),
        .resp (alu_resp),
        .data (alu_data)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_q    <= CMD_NOP;
            op1      <= '0;
            op2      <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cmd_q    <= cmd_n;
            op1      <= op1_n;
            op2      <= op2_n;
            out_resp <= resp_n;
            out_data <= data_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cmd_n   = cmd_q;
        op1_n   = op1;
        op2_n   = op2;
        resp_n  = RESP_NONE;
        data_n  = '0;
        busy_n  = busy;
        unique case (state)
            IDLE: begin
                if (req_cmd_in != CMD_NOP) begin
                    state_n = OPND2;
                    cmd_n   = req_cmd_in;
                    op1_n   = req_data_in;
                    busy_n  = 1'b1;
                end
            end
            OPND2: begin
                op2_n   = req_data_in;
                cnt_n   = '0;
                state_n = EXEC;
            end
            EXEC: begin
                // the edge leaving EXEC loads the response beat
                if (cnt == LAST) begin
                    state_n = RESP;
                    resp_n  = alu_resp;
                    data_n  = alu_data;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                if (req_cmd_in != CMD_NOP) begin
                    state_n = OPND2;
                    cmd_n   = req_cmd_in;
                    op1_n   = req_data_in;
                    busy_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
